lcg_frame_source: RTL and testbench

- Synthesizable stimulus source that sits directly upstream of the fuzz DUT `top` and drives its `in_flat` port.
- Produces WIDTH-bit frames built from consecutive 32-bit LCG words, using the same recurrence and chunk packing as the software bench. A hardware-driven run is therefore bit-identical to a bench-driven run for the same seed.
- Frames are handed over with a valid/ready handshake, and the block counts a programmed number of frames.

---
 rtl/lcg_frame_source.sv | 119 +++++++++++
 tb/tb_lcg_frame_source.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcg_frame_source.sv
// Stimulus source: packs consecutive 32-bit LCG words into WIDTH-bit frames
// and hands them over with a valid/ready handshake for a programmed frame count.
module lcg_frame_source #(
    parameter int          WIDTH        = 137,
    parameter logic [31:0] SEED_DEFAULT = 32'h15166570,
    parameter logic [31:0] MULT         = 32'h41C64E6D,
    parameter logic [31:0] INC          = 32'h3039
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic             start,
    input  logic [31:0]      frame_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      frames_sent,
    output logic [31:0]      rng_state_o
);
    localparam int NCHUNK = (WIDTH + 31) / 32;
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [31:0]       state;
    logic [31:0]       nxt;
    logic [31:0]       remaining;
    logic [CIDX_W-1:0] chunk_idx;
    logic [WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]  frame_next;

    function automatic logic [31:0] lcg_step(input logic [31:0] s);
        return s * MULT + INC;
    endfunction

    assign nxt         = lcg_step(state);
    assign busy        = (fsm == FILL) || (fsm == HOLD);
    assign done        = (fsm == DONE);
    assign rng_state_o = state;

    // Merge the current chunk into the partial frame; bits past WIDTH are dropped.
    always_comb begin
        frame_next = shadow;
        for (int i = 0; i < WIDTH; i++) begin
            if (i[CIDX_W+4:5] == chunk_idx) frame_next[i] = nxt[i[4:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE, DONE: begin
                if (start) fsm_nxt = (frame_count == 32'd0) ? DONE : FILL;
            end
            FILL: begin
                if (chunk_idx == LAST_IDX) fsm_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) fsm_nxt = (remaining == 32'd1) ? DONE : FILL;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Partial frame needs no reset: every bit is rewritten before it is presented.
    always_ff @(posedge clk) begin
        if (fsm == FILL) shadow <= frame_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEED_DEFAULT;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frames_sent <= 32'd0;
            remaining   <= 32'd0;
            chunk_idx   <= '0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (seed_load) state <= seed_in;
                    if (start) begin
                        remaining   <= frame_count;
                        frames_sent <= 32'd0;
                        chunk_idx   <= '0;
                    end
                end
                FILL: begin
                    state <= nxt;
                    if (chunk_idx == LAST_IDX) begin
                        out_data  <= frame_next;
                        out_valid <= 1'b1;
                        chunk_idx <= '0;
                    end else begin
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        frames_sent <= frames_sent + 32'd1;
                        remaining   <= remaining - 32'd1;
                        out_valid   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcg_frame_source.sv
// Randomized self-checking bench for lcg_frame_source against a software LCG frame model.
module tb_lcg_frame_source;
    localparam int          W    = 137;
    localparam int          NC   = (W + 31) / 32;
    localparam logic [31:0] SEED = 32'h15166570;
    localparam logic [31:0] MULT = 32'h41C64E6D;
    localparam logic [31:0] INC  = 32'h3039;

    logic          clk = 1'b0;
    logic          rst;
    logic          seed_load;
    logic [31:0]   seed_in;
    logic          start;
    logic [31:0]   frame_count;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          done;
    logic [31:0]   frames_sent;
    logic [31:0]   rng_state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] mstate;

    lcg_frame_source dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .start(start), .frame_count(frame_count), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
        .frames_sent(frames_sent), .rng_state_o(rng_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Software bench: NC consecutive LCG words, word k at bits [32k+31:32k].
    task automatic gen_frame(output logic [W-1:0] f);
        logic [NC*32-1:0] acc;
        logic [63:0]      prod;
        acc = '0;
        for (int k = 0; k < NC; k++) begin
            prod   = (64'(mstate) * 64'(MULT) + 64'(INC)) % 64'h1_0000_0000;
            mstate = prod[31:0];
            acc[32*k +: 32] = mstate;
        end
        f = acc[W-1:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic load, input logic [31:0] seed, input logic [31:0] cnt);
        seed_load   = load;
        seed_in     = seed;
        start       = 1'b1;
        frame_count = cnt;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_valid;
        for (int i = 0; i < 60 && !out_valid; i++) tick();
        if (!out_valid) check("valid_timeout", W'(out_valid), W'(1));
    endtask

    task automatic collect(input int n, input string tag);
        logic [W-1:0] exp;
        for (int f = 0; f < n; f++) begin
            wait_valid();
            gen_frame(exp);
            check(tag, out_data, exp);
            tick();
        end
    endtask

    initial begin
        logic [W-1:0] exp;
        logic [31:0]  snap, s;
        int           n, got, cyc;

        rst = 1'b1; seed_load = 0; seed_in = 0; start = 0; frame_count = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_data", out_data, W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_rng", W'(rng_state_o), W'(SEED));

        // Single frame from seed 0, latency and one-cycle valid
        out_ready = 1'b1;
        do_start(1'b1, 32'd0, 32'd1);
        mstate = 32'd0;
        for (int i = 1; i < NC; i++) begin
            tick();
            check("lat_low", W'(out_valid), W'(0));
        end
        tick();
        check("lat_high", W'(out_valid), W'(1));
        gen_frame(exp);
        check("seed0_frame", out_data, exp);
        check("seed0_w0", W'(out_data[31:0]), W'(32'h00003039));
        check("seed0_w1", W'(out_data[63:32]), W'(32'hD3DC167E));
        tick();
        check("seed0_vld_off", W'(out_valid), W'(0));
        check("seed0_sent", W'(frames_sent), W'(1));
        check("seed0_done", W'(done), W'(1));

        // Backpressure, continuing the sequence from DONE
        out_ready = 1'b0;
        do_start(1'b0, 32'd0, 32'd3);
        wait_valid();
        gen_frame(exp);
        snap = mstate;
        check("bp_frame0", out_data, exp);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_data", out_data, exp);
            check("bp_hold_rng", W'(rng_state_o), W'(snap));
            check("bp_hold_sent", W'(frames_sent), W'(0));
        end
        out_ready = 1'b1;
        tick();
        check("bp_sent1", W'(frames_sent), W'(1));
        collect(2, "bp_frame");
        check("bp_sent3", W'(frames_sent), W'(3));
        check("bp_done", W'(done), W'(1));

        // Zero count
        snap = rng_state_o;
        check("zc_rng_model", W'(snap), W'(mstate));
        do_start(1'b0, 32'd0, 32'd0);
        check("zc_done", W'(done), W'(1));
        check("zc_busy", W'(busy), W'(0));
        for (int i = 0; i < 6; i++) begin
            check("zc_novalid", W'(out_valid), W'(0));
            tick();
        end
        check("zc_rng", W'(rng_state_o), W'(snap));

        // Commands while busy are ignored
        s = $urandom;
        do_start(1'b1, s, 32'd2);
        mstate = s;
        tick();
        seed_load = 1'b1; seed_in = ~s; start = 1'b1; frame_count = 32'd7;
        tick();
        seed_load = 1'b0; start = 1'b0;
        collect(2, "busy_frame");
        check("busy_sent", W'(frames_sent), W'(2));
        check("busy_done", W'(done), W'(1));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("busy_novalid", W'(out_valid), W'(0));
        end

        // Asynchronous reset during chunk 2 of FILL
        do_start(1'b0, 32'd0, 32'd4);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("mrst_valid", W'(out_valid), W'(0));
        check("mrst_data", out_data, W'(0));
        check("mrst_busy", W'(busy), W'(0));
        check("mrst_done", W'(done), W'(0));
        check("mrst_rng", W'(rng_state_o), W'(SEED));
        check("mrst_sent", W'(frames_sent), W'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        mstate = SEED;
        do_start(1'b0, 32'd0, 32'd2);
        collect(2, "mrst_frame");
        check("mrst_sent2", W'(frames_sent), W'(2));

        // Random seeds, counts and out_ready
        for (int r = 0; r < 4; r++) begin
            s = $urandom;
            n = $urandom_range(1, 5);
            out_ready = 1'b0;
            do_start(1'b1, s, 32'(n));
            mstate = s;
            got = 0;
            gen_frame(exp);
            for (cyc = 0; cyc < 400 && !done; cyc++) begin
                if (out_valid) check("rnd_frame", out_data, exp);
                out_ready = 1'($urandom);
                if (out_valid && out_ready) begin
                    got++;
                    if (got < n) gen_frame(exp);
                end
                tick();
            end
            check("rnd_done", W'(done), W'(1));
            check("rnd_sent", W'(frames_sent), W'(n));
            check("rnd_count", W'(got), W'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
